// File: rtl/pipe_stage_reg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : pipe_stage_reg                                                |
// | Purpose  : Pipeline stage register with valid bit, stall hold, flush     |
// |            bubble insertion and optional stall/flush statistics.         |
// | Options  : define PIPE_STAT_EN to build the statistics counters.         |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module pipe_stage_reg #(
  parameter int                 WIDTH     = 32,
  parameter logic [WIDTH-1:0]   NOP_VALUE = {WIDTH{1'b0}},
  parameter int                 CNT_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  clrn,
  input  logic [WIDTH-1:0]      d,
  input  logic                  d_valid,
  input  logic                  stall,
  input  logic                  flush,
  input  logic                  cnt_clr,
  output logic [WIDTH-1:0]      q,
  output logic                  q_valid,
  output logic [CNT_WIDTH-1:0]  stall_cnt,
  output logic [CNT_WIDTH-1:0]  flush_cnt,
  output logic [CNT_WIDTH-1:0]  max_stall
);

  logic [WIDTH-1:0] r_q;
  logic             r_valid;

  // Flush beats stall beats load.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      r_q     <= NOP_VALUE;
      r_valid <= 1'b0;
    end else if (flush) begin
      r_q     <= NOP_VALUE;
      r_valid <= 1'b0;
    end else if (!stall) begin
      r_q     <= d;
      r_valid <= d_valid;
    end
  end

  assign q       = r_q;
  assign q_valid = r_valid;

`ifdef PIPE_STAT_EN
  localparam logic [CNT_WIDTH-1:0] c_cnt_max = {CNT_WIDTH{1'b1}};
  localparam logic [CNT_WIDTH-1:0] c_cnt_one = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  logic [CNT_WIDTH-1:0] r_stall_cnt;
  logic [CNT_WIDTH-1:0] r_flush_cnt;
  logic [CNT_WIDTH-1:0] r_max_stall;
  logic [CNT_WIDTH-1:0] r_run;
  logic                 w_stall_ev;
  logic [CNT_WIDTH-1:0] w_run_inc;

  assign w_stall_ev = stall & ~flush;
  assign w_run_inc  = (r_run == c_cnt_max) ? c_cnt_max : r_run + c_cnt_one;

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
      r_max_stall <= '0;
      r_run       <= '0;
    end else if (cnt_clr) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
      r_max_stall <= '0;
      r_run       <= '0;
    end else begin
      if (w_stall_ev) begin
        r_run <= w_run_inc;
        if (w_run_inc > r_max_stall)
          r_max_stall <= w_run_inc;
        // Only a stalled real instruction counts as a lost cycle.
        if (r_valid && (r_stall_cnt != c_cnt_max))
          r_stall_cnt <= r_stall_cnt + c_cnt_one;
      end else begin
        r_run <= '0;
      end
      if (flush && r_valid && (r_flush_cnt != c_cnt_max))
        r_flush_cnt <= r_flush_cnt + c_cnt_one;
    end
  end

  assign stall_cnt = r_stall_cnt;
  assign flush_cnt = r_flush_cnt;
  assign max_stall = r_max_stall;
`else
  logic w_unused_cnt_clr;
  assign w_unused_cnt_clr = cnt_clr;
  assign stall_cnt = '0;
  assign flush_cnt = '0;
  assign max_stall = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pipe_stage_reg.sv
`default_nettype none
// Randomized self-checking bench for pipe_stage_reg with a behavioural model
// plus directed scenarios pinned by literal expectations.
module tb_pipe_stage_reg;

  localparam int W    = 32;
  localparam int CW   = 4;
  localparam int CMAX = (1 << CW) - 1;
  localparam logic [W-1:0] NOP = 32'h0000_0013;

  logic          clk = 1'b0;
  logic          clrn;
  logic [W-1:0]  d = '0;
  logic          d_valid = 1'b0;
  logic          stall = 1'b0;
  logic          flush = 1'b0;
  logic          cnt_clr = 1'b0;
  logic [W-1:0]  q;
  logic          q_valid;
  logic [CW-1:0] stall_cnt, flush_cnt, max_stall;

  int n_cmp = 0;
  int n_bad = 0;

  pipe_stage_reg #(.WIDTH(W), .NOP_VALUE(NOP), .CNT_WIDTH(CW)) dut (
    .clk(clk), .clrn(clrn), .d(d), .d_valid(d_valid), .stall(stall),
    .flush(flush), .cnt_clr(cnt_clr), .q(q), .q_valid(q_valid),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt), .max_stall(max_stall)
  );

  always #5 clk = ~clk;

  // Statistics are only visible when the feature is built in.
  function automatic int st(input int v);
`ifdef PIPE_STAT_EN
    return v;
`else
    return 0;
`endif
  endfunction

  function automatic int sat(input int v);
    return (v > CMAX) ? CMAX : v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: plain integers, rules applied in order of the edge.
  logic [W-1:0] m_q = NOP;
  bit           m_v = 0;
  int           m_sc = 0, m_fc = 0, m_mx = 0, m_run = 0;
  bit           chk_en = 0;

  always @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      m_q = NOP; m_v = 0; m_sc = 0; m_fc = 0; m_mx = 0; m_run = 0;
    end else begin
      if (cnt_clr) begin
        m_sc = 0; m_fc = 0; m_mx = 0; m_run = 0;
      end else if (flush) begin
        if (m_v) m_fc = sat(m_fc + 1);
        m_run = 0;
      end else if (stall) begin
        if (m_v) m_sc = sat(m_sc + 1);
        m_run = sat(m_run + 1);
        if (m_run > m_mx) m_mx = m_run;
      end else begin
        m_run = 0;
      end
      if (flush) begin
        m_q = NOP; m_v = 0;
      end else if (!stall) begin
        m_q = d; m_v = d_valid;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("q", q, m_q);
      check("q_valid", q_valid, m_v);
      check("stall_cnt", stall_cnt, st(m_sc));
      check("flush_cnt", flush_cnt, st(m_fc));
      check("max_stall", max_stall, st(m_mx));
    end
  end

  // Apply inputs just after a falling edge, return after the next falling edge.
  task automatic step(input logic [W-1:0] dd, input logic dv, input logic s,
                      input logic f, input logic c);
    d = dd; d_valid = dv; stall = s; flush = f; cnt_clr = c;
    @(negedge clk);
  endtask

  task automatic pin(input string tag, input logic [W-1:0] eq, input logic ev,
                     input int es, input int ef, input int em);
    check({tag, ".q"}, q, eq);
    check({tag, ".v"}, q_valid, ev);
    check({tag, ".sc"}, stall_cnt, st(es));
    check({tag, ".fc"}, flush_cnt, st(ef));
    check({tag, ".mx"}, max_stall, st(em));
  endtask

  initial begin
    clrn = 1'b0;
    @(negedge clk);
    d = 32'hFFFF_FFFF; d_valid = 1'b1;
    repeat (3) @(negedge clk);
    pin("reset", NOP, 1'b0, 0, 0, 0);
    chk_en = 1;

    clrn = 1'b1;
    step(32'hDEAD_BEEF, 1, 0, 0, 0);
    pin("first_load", 32'hDEAD_BEEF, 1'b1, 0, 0, 0);

    step(32'h1234_5678, 1, 0, 0, 0);
    step(32'h0000_0001, 1, 1, 0, 0);
    step(32'h0000_0002, 1, 1, 0, 0);
    step(32'h0000_0003, 1, 1, 0, 0);
    pin("stall_hold", 32'h1234_5678, 1'b1, 3, 0, 3);
    step(32'hAAAA_5555, 1, 0, 0, 0);
    pin("stall_release", 32'hAAAA_5555, 1'b1, 3, 0, 3);

    step(32'h0BAD_0BAD, 1, 1, 1, 0);
    pin("flush_prio", NOP, 1'b0, 3, 1, 3);
    step(32'h0BAD_0BAD, 1, 0, 1, 0);
    pin("flush_empty", NOP, 1'b0, 3, 1, 3);

    step(32'h1111_1111, 1, 0, 0, 1);
    pin("clr_load", 32'h1111_1111, 1'b1, 0, 0, 0);
    repeat (5) step(32'h2222_2222, 1, 1, 0, 0);
    step(32'h3333_3333, 1, 0, 0, 0);
    repeat (2) step(32'h4444_4444, 1, 1, 0, 0);
    step(32'h5555_5555, 1, 0, 0, 0);
    pin("max_track", 32'h5555_5555, 1'b1, 7, 0, 5);
    step(32'h6666_6666, 1, 1, 0, 0);
    step(32'h6666_6666, 1, 1, 0, 1);
    pin("clr_in_stall", 32'h5555_5555, 1'b1, 0, 0, 0);
    step(32'h6666_6666, 1, 1, 0, 0);
    pin("resume", 32'h5555_5555, 1'b1, 1, 0, 1);

    repeat (20) step(32'h7777_7777, 1, 1, 0, 0);
    pin("saturate", 32'h5555_5555, 1'b1, 15, 0, 15);

    // Asynchronous reset in the middle of a stall run.
    d = 32'h7777_7777; d_valid = 1'b1; stall = 1'b1; flush = 1'b0; cnt_clr = 1'b0;
    #2 clrn = 1'b0;
    #1 pin("async_reset", NOP, 1'b0, 0, 0, 0);
    @(negedge clk);
    clrn = 1'b1;
    step(32'hCAFE_F00D, 1, 0, 0, 0);
    pin("after_reset", 32'hCAFE_F00D, 1'b1, 0, 0, 0);

    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 299) == 0) begin
        #($urandom_range(1, 8)) clrn = 1'b0;
        @(negedge clk);
        clrn = 1'b1;
      end
      step($urandom, 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 2) == 0),
           1'($urandom_range(0, 9) == 0), 1'($urandom_range(0, 60) == 0));
    end

    chk_en = 0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
